// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register implemented as a 2-entry skid FIFO.
// It also produces a one-cycle fetch redirect and a saturating back-pressure stall counter.
module ex_mem_reg #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               zero,
  input  logic               branch_en,
  input  logic               branch_inv,
  input  logic               jump,
  input  logic [XLEN-1:0]    target,
  input  logic [XLEN-1:0]    pc_plus4,
  input  logic [4:0]         rd,
  input  logic               reg_we,
  input  logic               mem_we,
  input  logic               mem_re,
  input  logic [XLEN-1:0]    store_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_wb_data,
  output logic [XLEN-1:0]    out_store_data,
  output logic [4:0]         out_rd,
  output logic               out_reg_we,
  output logic               out_mem_we,
  output logic               out_mem_re,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned DEPTH = 2;

  logic [XLEN-1:0]    r_wb_data    [DEPTH];
  logic [XLEN-1:0]    r_store_data [DEPTH];
  logic [4:0]         r_rd         [DEPTH];
  logic [DEPTH-1:0]   r_reg_we;
  logic [DEPTH-1:0]   r_mem_we;
  logic [DEPTH-1:0]   r_mem_re;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               r_redirect;
  logic [XLEN-1:0]    r_redirect_pc;
  logic [STALL_W-1:0] r_stall_cnt;

  logic               w_push;
  logic               w_pop;
  logic               w_taken;
  logic [XLEN-1:0]    w_wb_in;

  // Handshake status depends only on registered occupancy, never on out_ready.
  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);

  assign w_push  = in_valid & in_ready & ~flush;
  assign w_pop   = out_valid & out_ready & ~flush;
  assign w_taken = jump | (branch_en & (zero ^ branch_inv));
  assign w_wb_in = jump ? pc_plus4 : alu_result;

  // Occupancy and the wrap-around pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_wb_data[i]    <= '0;
        r_store_data[i] <= '0;
        r_rd[i]         <= 5'd0;
      end
      r_reg_we <= '0;
      r_mem_we <= '0;
      r_mem_re <= '0;
    end else if (w_push) begin
      r_wb_data[r_wr_ptr]    <= w_wb_in;
      r_store_data[r_wr_ptr] <= store_data;
      r_rd[r_wr_ptr]         <= rd;
      r_reg_we[r_wr_ptr]     <= reg_we;
      r_mem_we[r_wr_ptr]     <= mem_we;
      r_mem_re[r_wr_ptr]     <= mem_re;
    end
  end

  assign out_wb_data    = r_wb_data[r_rd_ptr];
  assign out_store_data = r_store_data[r_rd_ptr];
  assign out_rd         = r_rd[r_rd_ptr];
  assign out_reg_we     = r_reg_we[r_rd_ptr];
  assign out_mem_we     = r_mem_we[r_rd_ptr];
  assign out_mem_re     = r_mem_re[r_rd_ptr];

  // Redirect pulses for one cycle after a taken push; the target is held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_push & w_taken;
      if (w_push && w_taken) r_redirect_pc <= target;
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;

  // Saturating count of cycles where MEM holds off a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: a per-cycle vector table followed by
// hand-written stall-saturation and mid-transfer reset sequences.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, target, pc_plus4, store_data;
  logic        zero, branch_en, branch_inv, jump;
  logic [4:0]  rd;
  logic        reg_we, mem_we, mem_re, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_wb_data, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  logic        out_reg_we, out_mem_we, out_mem_re, redirect;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.XLEN(32), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .zero(zero),
    .branch_en(branch_en), .branch_inv(branch_inv), .jump(jump),
    .target(target), .pc_plus4(pc_plus4),
    .rd(rd), .reg_we(reg_we), .mem_we(mem_we), .mem_re(mem_re),
    .store_data(store_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_data(out_wb_data), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_we(out_mem_we),
    .out_mem_re(out_mem_re),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic        jmp, br, binv, z;
    logic [31:0] tgt, pc4;
    logic [4:0]  rd;
    logic        fl, ordy;
    logic        e_ov, e_ir;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_rdr;
    logic [31:0] e_rpc;
    logic [15:0] e_st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic iv, input logic [31:0] alu, input logic jmp, input logic br,
    input logic binv, input logic z, input logic [31:0] tgt, input logic [31:0] pc4,
    input logic [4:0] r, input logic fl, input logic ordy,
    input logic e_ov, input logic e_ir, input logic [31:0] e_wb, input logic [4:0] e_rd,
    input logic e_rdr, input logic [31:0] e_rpc, input logic [15:0] e_st);
    vec_t v;
    v.iv = iv; v.alu = alu; v.jmp = jmp; v.br = br; v.binv = binv; v.z = z;
    v.tgt = tgt; v.pc4 = pc4; v.rd = r; v.fl = fl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_wb = e_wb; v.e_rd = e_rd;
    v.e_rdr = e_rdr; v.e_rpc = e_rpc; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Store data and control flags are tied to rd so the bench can predict them from rd alone.
  task automatic apply(input vec_t v);
    in_valid   = v.iv;  alu_result = v.alu; jump = v.jmp; branch_en = v.br;
    branch_inv = v.binv; zero = v.z; target = v.tgt; pc_plus4 = v.pc4;
    rd = v.rd; reg_we = v.rd[0]; mem_we = v.rd[1]; mem_re = v.rd[2];
    store_data = 32'h5000_0000 | 32'(v.rd);
    flush = v.fl; out_ready = v.ordy;
  endtask

  task automatic chk_entry(input string pfx, input logic [31:0] e_wb, input logic [4:0] e_rd);
    logic [31:0] e_sd;
    e_sd = 32'h5000_0000 | 32'(e_rd);
    chk({pfx, "_wb"}, 64'(out_wb_data), 64'(e_wb));
    chk({pfx, "_rd"}, 64'(out_rd), 64'(e_rd));
    chk({pfx, "_sd"}, 64'(out_store_data), 64'(e_sd));
    chk({pfx, "_flags"}, 64'({out_mem_re, out_mem_we, out_reg_we}), 64'(e_rd[2:0]));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ov"},    64'(out_valid), 64'(0));
    chk({pfx, "_rdr"},   64'(redirect), 64'(0));
    chk({pfx, "_rpc"},   64'(redirect_pc), 64'(0));
    chk({pfx, "_stall"}, 64'(stall_cnt), 64'(0));
    chk({pfx, "_wb"},    64'(out_wb_data), 64'(0));
    chk({pfx, "_sd"},    64'(out_store_data), 64'(0));
    chk({pfx, "_rd"},    64'(out_rd), 64'(0));
    chk({pfx, "_flags"}, 64'({out_mem_re, out_mem_we, out_reg_we}), 64'(0));
  endtask

  vec_t idle;

  initial begin
    rst_n = 1'b0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    apply(idle);
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ir", 64'(in_ready), 64'(1));

    //      iv alu         jmp br binv z tgt        pc4       rd fl ordy | ov ir wb          rd rdr rpc        stall
    vq.push_back(mk(1, 32'h10,  0, 0, 0, 0, 32'h0,   32'h0,    1, 0, 1,  1, 1, 32'h10,  1, 0, 32'h0,   0));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h0,   0));
    // back-pressure: third push refused, stall counter advances
    vq.push_back(mk(1, 32'h20,  0, 0, 0, 0, 32'h0,   32'h0,    2, 0, 0,  1, 1, 32'h20,  2, 0, 32'h0,   0));
    vq.push_back(mk(1, 32'h30,  0, 0, 0, 0, 32'h0,   32'h0,    3, 0, 0,  1, 0, 32'h20,  2, 0, 32'h0,   1));
    vq.push_back(mk(1, 32'h40,  0, 0, 0, 0, 32'h0,   32'h0,    4, 0, 0,  1, 0, 32'h20,  2, 0, 32'h0,   2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  1, 1, 32'h30,  3, 0, 32'h0,   2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h0,   2));
    // branch taken, branch inverted not taken, inverted taken
    vq.push_back(mk(1, 32'h50,  0, 1, 0, 1, 32'h200, 32'h0,    5, 0, 1,  1, 1, 32'h50,  5, 1, 32'h200, 2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h200, 2));
    vq.push_back(mk(1, 32'h60,  0, 1, 1, 1, 32'h300, 32'h0,    6, 0, 1,  1, 1, 32'h60,  6, 0, 32'h200, 2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h200, 2));
    vq.push_back(mk(1, 32'h70,  0, 1, 1, 0, 32'h240, 32'h0,    7, 0, 1,  1, 1, 32'h70,  7, 1, 32'h240, 2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h240, 2));
    // jump writes back the link value
    vq.push_back(mk(1, 32'h999, 1, 0, 0, 0, 32'h80,  32'h104,  8, 0, 1,  1, 1, 32'h104, 8, 1, 32'h80,  2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h80,  2));
    // simultaneous push and pop keep occupancy at one
    vq.push_back(mk(1, 32'hA0,  0, 0, 0, 0, 32'h0,   32'h0,    9, 0, 0,  1, 1, 32'hA0,  9, 0, 32'h80,  2));
    vq.push_back(mk(1, 32'hB0,  0, 0, 0, 0, 32'h0,   32'h0,   10, 0, 1,  1, 1, 32'hB0, 10, 0, 32'h80,  2));
    vq.push_back(mk(1, 32'hC0,  0, 0, 0, 0, 32'h0,   32'h0,   11, 0, 1,  1, 1, 32'hC0, 11, 0, 32'h80,  2));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h80,  2));
    // flush at full occupancy with a taken jump on the input, then flush with room
    vq.push_back(mk(1, 32'hD0,  0, 0, 0, 0, 32'h0,   32'h0,   12, 0, 0,  1, 1, 32'hD0, 12, 0, 32'h80,  2));
    vq.push_back(mk(1, 32'hE0,  0, 0, 0, 0, 32'h0,   32'h0,   13, 0, 0,  1, 0, 32'hD0, 12, 0, 32'h80,  3));
    vq.push_back(mk(1, 32'hF1,  1, 0, 0, 0, 32'h44,  32'h48,  14, 1, 0,  0, 1, 32'h0,   0, 0, 32'h80,  3));
    vq.push_back(mk(1, 32'hF2,  1, 0, 0, 0, 32'h55,  32'h58,  15, 1, 0,  0, 1, 32'h0,   0, 0, 32'h80,  3));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h80,  3));
    // branch-only entry (not taken, no write enables) still occupies and pops
    vq.push_back(mk(1, 32'hF0,  0, 1, 0, 0, 32'h900, 32'h0,    0, 0, 1,  1, 1, 32'hF0,  0, 0, 32'h80,  3));
    vq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,    0, 0, 1,  0, 1, 32'h0,   0, 0, 32'h80,  3));

    for (int i = 0; i < vq.size(); i++) begin
      string p;
      p = $sformatf("v%0d", i);
      apply(vq[i]);
      @(posedge clk);
      #1;
      chk({p, "_ov"},    64'(out_valid), 64'(vq[i].e_ov));
      chk({p, "_ir"},    64'(in_ready), 64'(vq[i].e_ir));
      chk({p, "_rdr"},   64'(redirect), 64'(vq[i].e_rdr));
      chk({p, "_rpc"},   64'(redirect_pc), 64'(vq[i].e_rpc));
      chk({p, "_stall"}, 64'(stall_cnt), 64'(vq[i].e_st));
      if (vq[i].e_ov) chk_entry(p, vq[i].e_wb, vq[i].e_rd);
    end

    // Long stall drives the counter from 3 into saturation.
    apply(mk(1, 32'h111, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    apply(mk(0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall", 64'(stall_cnt), 64'(16'hFFFF));
    chk("sat_ov", 64'(out_valid), 64'(1));
    chk_entry("sat", 32'h111, 5'd1);

    // Taken jump while saturated; counter must not wrap.
    apply(mk(1, 32'h0, 1, 0, 0, 0, 32'h4000, 32'h4004, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("sat2_stall", 64'(stall_cnt), 64'(16'hFFFF));
    chk("sat2_rdr", 64'(redirect), 64'(1));
    chk("sat2_rpc", 64'(redirect_pc), 64'(32'h4000));
    chk("sat2_ir", 64'(in_ready), 64'(0));
    apply(mk(0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-stall with a redirect pending.
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(idle);
    @(posedge clk);
    #1;
    chk("post_ov", 64'(out_valid), 64'(0));
    chk("post_rdr", 64'(redirect), 64'(0));
    chk("post_ir", 64'(in_ready), 64'(1));
    chk("post_stall", 64'(stall_cnt), 64'(0));
    @(posedge clk);
    #1;
    chk("post2_ov", 64'(out_valid), 64'(0));
    chk("post2_rdr", 64'(redirect), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of result, target, PC and store data.
REQ-002 SHALL have parameter STALL_W, default 16, width of the back-pressure stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  EX stage presents an instruction.
REQ-006 in_ready  output  1  buffer can accept this cycle.
REQ-007 alu_result  input  XLEN  ALU result (address or arithmetic value).
REQ-008 zero  input  1  ALU zero flag.
REQ-009 branch_en, branch_inv, jump  input  1 each  branch instruction; invert zero sense; JAL/JALR.
REQ-010 target  input  XLEN  precomputed branch/jump target.
REQ-011 pc_plus4  input  XLEN  link value.
REQ-012 rd  input  5;  reg_we, mem_we, mem_re  input  1 each;  store_data  input  XLEN.
REQ-013 flush  input  1  kill all buffered and incoming work.
REQ-014 out_valid  output  1;  out_ready  input  1  MEM-side handshake.
REQ-015 out_wb_data, out_store_data  output  XLEN;  out_rd  output  5;  out_reg_we, out_mem_we, out_mem_re  output  1.
REQ-016 redirect  output  1;  redirect_pc  output  XLEN  fetch redirect.
REQ-017 stall_cnt  output  STALL_W  saturating count of stalled cycles.

Function
REQ-018 SHALL hold a 2-entry FIFO (skid buffer) of {wb_data, store_data, rd, reg_we, mem_we, mem_re}; occupancy 0..2.
REQ-019 in_ready SHALL equal (occupancy < 2), combinationally from registered occupancy only, never from out_ready.
REQ-020 Push SHALL occur when in_valid & in_ready & !flush; pop when out_valid & out_ready & !flush.
REQ-021 Stored wb_data SHALL be pc_plus4 when jump=1, else alu_result.
REQ-022 out_* SHALL present the oldest entry; out_valid = (occupancy != 0); latency in->out one cycle when empty.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; pointers SHALL wrap modulo 2.
REQ-024 With occupancy 2, in_ready=0; input ignored regardless of in_valid.
REQ-025 Taken SHALL be jump | (branch_en & (zero ^ branch_inv)), evaluated at push only.
REQ-026 redirect SHALL pulse exactly one cycle, the cycle after a push with taken=1; redirect_pc SHALL be registered target from that push, holding value until next taken push.
REQ-027 flush SHALL, next edge: occupancy=0, redirect=0, drop any concurrent push (no redirect generated), stall_cnt unchanged.
REQ-028 stall_cnt SHALL increment each cycle out_valid & !out_ready & !flush, saturate at all-ones, never wrap.
REQ-029 Branch-only entries (branch_en=1, reg_we=mem_we=mem_re=0) SHALL still occupy a slot and be popped normally.
REQ-030 Outputs SHALL be X-free whenever out_valid=1; data fields with out_valid=0 are don't-care but SHALL be 0 after reset.

Reset
REQ-031 On rst_n=0, asynchronously: occupancy=0, out_valid=0, in_ready=1 after release, redirect=0, redirect_pc=0, stall_cnt=0, all buffered fields=0.
REQ-032 Reset asserted mid-transfer SHALL discard all entries and any pending redirect; no pop or redirect after release until a new push.

Verification
REQ-033 Push alu_result=0x10, jump=0, out_ready=1 -> next cycle out_valid=1, out_wb_data=0x10; following cycle out_valid=0.
REQ-034 out_ready=0, push 3 back-to-back -> first two accepted, in_ready=0 on third; stall_cnt counts; then out_ready=1 -> entries exit in order, in_ready returns 1.
REQ-035 Push branch_en=1, zero=1, branch_inv=0, target=0x200 -> redirect=1 one cycle, redirect_pc=0x200; same with branch_inv=1 -> no redirect.
REQ-036 Push jump=1, pc_plus4=0x104, target=0x80 -> out_wb_data=0x104, redirect_pc=0x80.
REQ-037 Occupancy 2 plus in_valid with flush=1 -> next cycle out_valid=0, no redirect, occupancy 0.
REQ-038 Force stall_cnt to 0xFFFF with out_valid=1, out_ready=0 -> stays 0xFFFF; rst_n low mid-stall -> all outputs 0 immediately.
